// File: rtl/silife_population.sv
// Post-generation statistics scanner: walks every grid row once per generation and
// reports population, generation count, extinction and stable-state flags.
module silife_population #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned HEIGHT = 32,
   localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
   localparam int unsigned PW = $clog2(WIDTH * HEIGHT + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_generation,
   input  logic             i_clear,
   output logic [RW-1:0]    o_row_select,
   input  logic [WIDTH-1:0] i_cells,
   output logic             o_busy,
   output logic             o_valid,
   output logic [PW-1:0]    o_population,
   output logic [31:0]      o_generation,
   output logic             o_extinct,
   output logic             o_stable
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             pending_q, pending_d;
   logic             have_prev_q, have_prev_d;
   logic [PW-1:0]    prev_pop_q, prev_pop_d;
   logic [WIDTH-1:0] prev_sum_q, prev_sum_d;
   logic [31:0]      gen_q, gen_d;
   logic [PW-1:0]    pop_q, pop_d;
   logic             ext_q, ext_d;
   logic             stable_q, stable_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [PW-1:0]    row_pop;
   logic [PW-1:0]    acc_nxt;
   logic [WIDTH-1:0] sum_nxt;

   // Next-state, accumulation and result latching
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      pending_d   = pending_q;
      have_prev_d = have_prev_q;
      prev_pop_d  = prev_pop_q;
      prev_sum_d  = prev_sum_q;
      gen_d       = gen_q;
      pop_d       = pop_q;
      ext_d       = ext_q;
      stable_d    = stable_q;
      valid_d     = 1'b0;
      busy_d      = busy_q;

      row_pop = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         row_pop = row_pop + PW'(i_cells[i]);
      end
      acc_nxt = acc_q + row_pop;
      sum_nxt = {sum_q[WIDTH-2:0], sum_q[WIDTH-1]} ^ i_cells;

      if (i_clear) begin
         state_d     = IDLE;
         row_d       = '0;
         busy_d      = 1'b0;
         gen_d       = '0;
         pop_d       = '0;
         ext_d       = 1'b0;
         stable_d    = 1'b0;
         have_prev_d = 1'b0;
         pending_d   = 1'b0;
      end else begin
         if (i_generation) begin
            gen_d = gen_q + 32'd1;
         end
         case (state_q)
            IDLE: begin
               if (i_generation) begin
                  state_d   = SCAN;
                  row_d     = '0;
                  acc_d     = '0;
                  sum_d     = '0;
                  pending_d = 1'b0;
                  busy_d    = 1'b1;
               end
            end
            SCAN: begin
               acc_d = acc_nxt;
               sum_d = sum_nxt;
               if (i_generation) begin
                  pending_d = 1'b1;
               end
               // Results are latched as the last row is sampled so they are visible in DONE
               if (row_q == RW'(HEIGHT - 1)) begin
                  state_d     = DONE;
                  row_d       = '0;
                  busy_d      = pending_q | i_generation;
                  pop_d       = acc_nxt;
                  ext_d       = (acc_nxt == '0);
                  stable_d    = have_prev_q && (acc_nxt == prev_pop_q) && (sum_nxt == prev_sum_q);
                  prev_pop_d  = acc_nxt;
                  prev_sum_d  = sum_nxt;
                  have_prev_d = 1'b1;
                  valid_d     = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
            DONE: begin
               if (pending_q || i_generation) begin
                  state_d   = SCAN;
                  row_d     = '0;
                  acc_d     = '0;
                  sum_d     = '0;
                  pending_d = 1'b0;
                  busy_d    = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         pending_q   <= 1'b0;
         have_prev_q <= 1'b0;
         prev_pop_q  <= '0;
         prev_sum_q  <= '0;
         gen_q       <= '0;
         pop_q       <= '0;
         ext_q       <= 1'b0;
         stable_q    <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         pending_q   <= pending_d;
         have_prev_q <= have_prev_d;
         prev_pop_q  <= prev_pop_d;
         prev_sum_q  <= prev_sum_d;
         gen_q       <= gen_d;
         pop_q       <= pop_d;
         ext_q       <= ext_d;
         stable_q    <= stable_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
      end
   end

   assign o_row_select = row_q;
   assign o_busy       = busy_q;
   assign o_valid      = valid_q;
   assign o_population = pop_q;
   assign o_generation = gen_q;
   assign o_extinct    = ext_q;
   assign o_stable     = stable_q;

endmodule

// File: tb/tb_silife_population.sv
// Scoreboard bench for silife_population: a bench-side row memory feeds i_cells, and each
// expected result (with its arrival cycle) is queued at stimulus time and popped on o_valid.
module tb_silife_population;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned HEIGHT = 32;
   localparam int unsigned RW     = $clog2(HEIGHT);
   localparam int unsigned PW     = $clog2(WIDTH * HEIGHT + 1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             i_generation = 1'b0;
   logic             i_clear = 1'b0;
   logic [RW-1:0]    o_row_select;
   logic [WIDTH-1:0] i_cells;
   logic             o_busy;
   logic             o_valid;
   logic [PW-1:0]    o_population;
   logic [31:0]      o_generation;
   logic             o_extinct;
   logic             o_stable;

   logic [WIDTH-1:0] mem [HEIGHT];

   typedef struct {
      int unsigned cyc;
      int unsigned pop;
      int unsigned gen;
      bit          ext;
      bit          stb;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned t;

   silife_population #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_generation (i_generation),
      .i_clear      (i_clear),
      .o_row_select (o_row_select),
      .i_cells      (i_cells),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_population (o_population),
      .o_generation (o_generation),
      .o_extinct    (o_extinct),
      .o_stable     (o_stable)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always_comb i_cells = mem[o_row_select];

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every o_valid must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && o_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            check("valid_cycle", cyc, e.cyc);
            check("population", o_population, e.pop);
            check("generation", o_generation, e.gen);
            check("extinct", o_extinct, e.ext);
            check("stable", o_stable, e.stb);
         end
      end
   end

   task automatic pulse(input bit push, input int unsigned pop, input int unsigned gen,
                        input bit ext, input bit stb, output int unsigned tp);
      @(posedge clk); #1;
      i_generation = 1'b1;
      tp = cyc;
      if (push) sb.push_back('{tp + HEIGHT + 1, pop, gen, ext, stb});
      @(posedge clk); #1;
      i_generation = 1'b0;
   endtask

   task automatic wait_cycle(input int unsigned target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_row(input int unsigned r);
      int n = 0;
      while (o_row_select != RW'(r) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_row: got row %0d expected %0d within 100 cycles", o_row_select, r);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [WIDTH-1:0] v);
      for (int i = 0; i < HEIGHT; i++) mem[i] = v;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_row"}, o_row_select, 0);
      check({tag, "_valid"}, o_valid, 0);
      check({tag, "_pop"}, o_population, 0);
      check({tag, "_gen"}, o_generation, 0);
      check({tag, "_ext"}, o_extinct, 0);
      check({tag, "_stable"}, o_stable, 0);
   endtask

   initial begin
      fill('0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // Blinker: population 3, then stable on an identical rescan
      mem[5] = 32'h0000_0007;
      pulse(1, 3, 1, 0, 0, t);
      check("start_busy", o_busy, 1);
      check("start_row", o_row_select, 0);
      check("gen_after_pulse", o_generation, 1);
      wait_cycle(t + 5);
      check("row_at_t5", o_row_select, 4);
      wait_cycle(t + HEIGHT + 1);
      check("done_busy", o_busy, 0);
      wait_cycle(t + HEIGHT + 2);
      check("idle_busy", o_busy, 0);
      check("idle_row", o_row_select, 0);
      drain();
      pulse(1, 3, 2, 0, 1, t);
      drain();

      // Full then empty grid
      fill('1);
      pulse(1, 1024, 3, 0, 0, t);
      drain();
      fill('0);
      pulse(1, 0, 4, 1, 0, t);
      drain();

      // Same population shifted by one row must not read as stable
      mem[5] = 32'h0000_0007;
      pulse(1, 3, 5, 0, 0, t);
      drain();
      mem[5] = '0;
      mem[6] = 32'h0000_0007;
      pulse(1, 3, 6, 0, 0, t);
      drain();

      // Extra pulses mid-scan collapse into a single rescan
      @(posedge clk); #1;
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      check("gen_after_clear", o_generation, 0);
      pulse(1, 3, 3, 0, 0, t);
      sb.push_back('{t + 2 * HEIGHT + 2, 3, 3, 0, 1});
      wait_row(10);
      i_generation = 1'b1;
      @(posedge clk); #1;
      i_generation = 1'b0;
      @(posedge clk); #1;
      i_generation = 1'b1;
      @(posedge clk); #1;
      i_generation = 1'b0;
      check("gen_midscan", o_generation, 3);
      wait_cycle(t + HEIGHT + 1);
      check("done_busy_pending", o_busy, 1);
      wait_cycle(t + HEIGHT + 2);
      check("rescan_busy", o_busy, 1);
      check("rescan_row", o_row_select, 0);
      wait_cycle(t + HEIGHT + 3);
      check("rescan_row1", o_row_select, 1);
      drain();
      check("after_rescan_busy", o_busy, 0);

      // Clear mid-scan aborts without o_valid
      pulse(0, 0, 0, 0, 0, t);
      wait_row(5);
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      check("clr_busy", o_busy, 0);
      check("clr_gen", o_generation, 0);
      check("clr_pop", o_population, 0);
      check("clr_stable", o_stable, 0);
      check("clr_row", o_row_select, 0);
      repeat (45) @(posedge clk);
      #1;
      check("clr_still_idle", o_busy, 0);

      // Clear wins over a simultaneous generation pulse
      i_clear = 1'b1;
      i_generation = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      i_generation = 1'b0;
      check("clrgen_gen", o_generation, 0);
      check("clrgen_busy", o_busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("clrgen_idle", o_busy, 0);

      // Asynchronous reset at row 12, then a fresh scan from row 0
      pulse(0, 0, 0, 0, 0, t);
      wait_row(12);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      sb.delete();
      @(posedge clk); #1;
      check("rst_held_busy", o_busy, 0);
      reset_n = 1'b1;
      pulse(1, 3, 1, 0, 0, t);
      check("restart_row", o_row_select, 0);
      check("restart_busy", o_busy, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
